// File: rtl/mem_arbiter_pkg.sv
// Types shared by the memory arbiter and its request buffers.
// One request record describes a buffered request and the registered memory port.
package mem_arbiter_pkg;

    localparam int ARB_XLEN = 32;
    localparam int ARB_STRB = ARB_XLEN / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } arbiter_state_type;

    typedef struct packed {
        logic                valid;
        logic                instr;
        logic [ARB_XLEN-1:0] addr;
        logic [ARB_XLEN-1:0] wdata;
        logic [ARB_STRB-1:0] wstrb;
    } mem_req_type;

    localparam mem_req_type init_mem_req = '0;

    function automatic mem_req_type make_req(
        input logic                valid,
        input logic                instr,
        input logic [ARB_XLEN-1:0] addr,
        input logic [ARB_XLEN-1:0] wdata,
        input logic [ARB_STRB-1:0] wstrb
    );
        mem_req_type r;
        r.valid = valid;
        r.instr = instr;
        r.addr  = addr;
        r.wdata = wdata;
        r.wstrb = wstrb;
        return r;
    endfunction

endpackage

// File: rtl/mem_req_buffer.sv
// One-entry request holding register: captures a request, keeps it until granted
// or flushed.
module mem_req_buffer
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic        flush,
    input  mem_req_type req_in,
    output mem_req_type req
);

    // A load in the same cycle as a flush survives: the new request follows the flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req <= init_mem_req;
        end else if (clear) begin
            req <= init_mem_req;
        end else if (load) begin
            req <= req_in;
        end else if (flush) begin
            req <= init_mem_req;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with
// starvation protection for fetch and flush handling for in-flight fetches.
//
// state | meaning
// IDLE  | no request outstanding on the memory port
// IBUSY | fetch issued, waiting for mem_ready
// DBUSY | load/store issued, waiting for mem_ready
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int XLEN       = ARB_XLEN,
    parameter int STARVE_MAX = 4
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              imem_valid,
    input  logic [XLEN-1:0]   imem_addr,
    input  logic              imem_flush,
    output logic              imem_ready,
    output logic [XLEN-1:0]   imem_rdata,
    input  logic              dmem_valid,
    input  logic [XLEN-1:0]   dmem_addr,
    input  logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN/8-1:0] dmem_wstrb,
    output logic              dmem_ready,
    output logic [XLEN-1:0]   dmem_rdata,
    output logic              mem_valid,
    output logic              mem_instr,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arbiter_state_type state, state_nxt;
    mem_req_type       ibuf, dbuf, iin, din, icand, dcand, mem_q;
    logic [SW-1:0]     starve_cnt;
    logic              drop_q;
    logic [XLEN-1:0]   irdata_q, drdata_q;

    logic arb_free, ibuf_live, ifetch_live, i_accept, d_accept;
    logic i_pend, starved, grant_i, grant_d;

    assign arb_free    = (state == IDLE) || mem_ready;
    assign ibuf_live   = ibuf.valid && !imem_flush;
    assign ifetch_live = (state == IBUSY) && !mem_ready && !drop_q;

    // A fetch pulse is accepted unless one is still live; a flush frees the slot.
    assign i_accept = imem_valid && !((ibuf.valid || ifetch_live) && !imem_flush);
    assign d_accept = dmem_valid && !(dbuf.valid || ((state == DBUSY) && !mem_ready));

    assign iin   = make_req(i_accept, 1'b1, imem_addr, '0, '0);
    assign din   = make_req(d_accept, 1'b0, dmem_addr, dmem_wdata, dmem_wstrb);
    assign icand = ibuf_live ? ibuf : iin;
    assign dcand = dbuf.valid ? dbuf : din;

    assign i_pend  = icand.valid;
    assign starved = i_pend && (starve_cnt == STARVE_LIM);
    assign grant_d = arb_free && dcand.valid && !starved;
    assign grant_i = arb_free && i_pend && !grant_d;

    mem_req_buffer u_ibuf (
        .clk    (clk),
        .rst    (rst),
        .load   (i_accept && !grant_i),
        .clear  (grant_i),
        .flush  (imem_flush),
        .req_in (iin),
        .req    (ibuf)
    );

    mem_req_buffer u_dbuf (
        .clk    (clk),
        .rst    (rst),
        .load   (d_accept && !grant_d),
        .clear  (grant_d),
        .flush  (1'b0),
        .req_in (din),
        .req    (dbuf)
    );

    always_comb begin
        state_nxt = state;
        if (arb_free) begin
            if (grant_d) begin
                state_nxt = DBUSY;
            end else if (grant_i) begin
                state_nxt = IBUSY;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            mem_q      <= init_mem_req;
            starve_cnt <= '0;
            drop_q     <= 1'b0;
            irdata_q   <= '0;
            drdata_q   <= '0;
        end else begin
            state <= state_nxt;

            if (grant_d) begin
                mem_q <= dcand;
            end else if (grant_i) begin
                mem_q <= icand;
            end else begin
                mem_q.valid <= 1'b0;
            end

            if (grant_i || !i_pend) begin
                starve_cnt <= '0;
            end else if (grant_d && (starve_cnt != STARVE_LIM)) begin
                starve_cnt <= starve_cnt + SW'(1);
            end

            if ((state == IBUSY) && mem_ready) begin
                drop_q <= 1'b0;
            end else if ((state == IBUSY) && imem_flush) begin
                drop_q <= 1'b1;
            end

            if (imem_ready) irdata_q <= mem_rdata;
            if (dmem_ready) drdata_q <= mem_rdata;
        end
    end

    // A flushed fetch's response is swallowed, including one landing in the flush cycle.
    assign imem_ready = (state == IBUSY) && mem_ready && !drop_q && !imem_flush;
    assign dmem_ready = (state == DBUSY) && mem_ready;
    assign imem_rdata = imem_ready ? mem_rdata : irdata_q;
    assign dmem_rdata = dmem_ready ? mem_rdata : drdata_q;

    assign mem_valid = mem_q.valid;
    assign mem_instr = mem_q.instr;
    assign mem_addr  = mem_q.addr;
    assign mem_wdata = mem_q.wdata;
    assign mem_wstrb = mem_q.wstrb;

    a_imem_protocol: assert property (@(posedge clk) disable iff (!rst) imem_valid |-> i_accept);
    a_dmem_protocol: assert property (@(posedge clk) disable iff (!rst) dmem_valid |-> d_accept);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays the memory and checks each
// handshake against hand-computed values.
module tb_mem_arbiter;

    localparam int XLEN = 32;

    logic              rst, clk;
    logic              imem_valid, imem_flush, imem_ready;
    logic [XLEN-1:0]   imem_addr, imem_rdata;
    logic              dmem_valid, dmem_ready;
    logic [XLEN-1:0]   dmem_addr, dmem_wdata, dmem_rdata;
    logic [XLEN/8-1:0] dmem_wstrb;
    logic              mem_valid, mem_instr, mem_ready;
    logic [XLEN-1:0]   mem_addr, mem_wdata, mem_rdata;
    logic [XLEN/8-1:0] mem_wstrb;

    int n_checks = 0;
    int n_pass   = 0;

    mem_arbiter #(.XLEN(XLEN), .STARVE_MAX(4)) dut (
        .rst        (rst),
        .clk        (clk),
        .imem_valid (imem_valid),
        .imem_addr  (imem_addr),
        .imem_flush (imem_flush),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .dmem_valid (dmem_valid),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Start a new cycle 1 time unit after the rising edge with all pulses low.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        imem_flush = 1'b0;
        mem_ready  = 1'b0;
    endtask

    task automatic settle();
        #3;
    endtask

    initial begin
        rst        = 1'b0;
        imem_valid = 1'b0;
        imem_addr  = '0;
        imem_flush = 1'b0;
        dmem_valid = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;
        dmem_wstrb = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_valid",  32'(mem_valid),  32'h0);
        chk("rst_mem_addr",   mem_addr,        32'h0);
        chk("rst_mem_wstrb",  32'(mem_wstrb),  32'h0);
        chk("rst_imem_rdata", imem_rdata,      32'h0);
        chk("rst_dmem_rdata", dmem_rdata,      32'h0);
        rst = 1'b1;

        // single fetch
        next_cycle(); imem_valid = 1'b1; imem_addr = 32'h100; settle();
        chk("fetch_no_early_valid", 32'(mem_valid), 32'h0);
        next_cycle(); settle();
        chk("fetch_mem_valid", 32'(mem_valid), 32'h1);
        chk("fetch_mem_instr", 32'(mem_instr), 32'h1);
        chk("fetch_mem_addr",  mem_addr,       32'h100);
        next_cycle(); settle();
        chk("fetch_valid_drop", 32'(mem_valid), 32'h0);
        chk("fetch_addr_hold",  mem_addr,       32'h100);
        next_cycle(); mem_ready = 1'b1; mem_rdata = 32'h13; settle();
        chk("fetch_imem_ready", 32'(imem_ready), 32'h1);
        chk("fetch_imem_rdata", imem_rdata,      32'h13);
        chk("fetch_no_dready",  32'(dmem_ready), 32'h0);
        next_cycle(); mem_rdata = 32'h55; settle();
        chk("fetch_ready_low",  32'(imem_ready), 32'h0);
        chk("fetch_rdata_hold", imem_rdata,      32'h13);

        // collision: dmem first, fetch right after the dmem response
        next_cycle();
        imem_valid = 1'b1; imem_addr = 32'h200;
        dmem_valid = 1'b1; dmem_addr = 32'h8000; dmem_wstrb = 4'h0;
        settle();
        next_cycle(); settle();
        chk("coll_d_valid", 32'(mem_valid), 32'h1);
        chk("coll_d_instr", 32'(mem_instr), 32'h0);
        chk("coll_d_addr",  mem_addr,       32'h8000);
        next_cycle(); mem_ready = 1'b1; mem_rdata = 32'hCAFE0001; settle();
        chk("coll_dready",  32'(dmem_ready), 32'h1);
        chk("coll_drdata",  dmem_rdata,      32'hCAFE0001);
        chk("coll_no_iready", 32'(imem_ready), 32'h0);
        next_cycle(); settle();
        chk("coll_i_valid", 32'(mem_valid), 32'h1);
        chk("coll_i_instr", 32'(mem_instr), 32'h1);
        chk("coll_i_addr",  mem_addr,       32'h200);
        next_cycle(); mem_ready = 1'b1; mem_rdata = 32'h00500093; settle();
        chk("coll_iready",  32'(imem_ready), 32'h1);
        chk("coll_irdata",  imem_rdata,      32'h00500093);
        chk("coll_drdata_hold", dmem_rdata,  32'hCAFE0001);

        // starvation: imem waits through exactly four dmem grants
        next_cycle();
        imem_valid = 1'b1; imem_addr = 32'h400;
        dmem_valid = 1'b1; dmem_addr = 32'h9000;
        settle();
        for (int k = 0; k < 4; k++) begin
            next_cycle(); settle();
            chk("starve_d_valid", 32'(mem_valid), 32'h1);
            chk("starve_d_instr", 32'(mem_instr), 32'h0);
            chk("starve_d_addr",  mem_addr,       32'h9000 + 32'(4 * k));
            next_cycle();
            mem_ready = 1'b1; mem_rdata = 32'(k);
            dmem_valid = 1'b1; dmem_addr = 32'h9000 + 32'(4 * (k + 1));
            settle();
            chk("starve_dready", 32'(dmem_ready), 32'h1);
        end
        next_cycle(); settle();
        chk("starve_i_valid", 32'(mem_valid), 32'h1);
        chk("starve_i_instr", 32'(mem_instr), 32'h1);
        chk("starve_i_addr",  mem_addr,       32'h400);
        chk("starve_cnt_zero", 32'(dut.starve_cnt), 32'h0);
        next_cycle(); mem_ready = 1'b1; mem_rdata = 32'h11; settle();
        chk("starve_iready", 32'(imem_ready), 32'h1);
        next_cycle(); settle();
        chk("starve_after_addr",  mem_addr,       32'h9010);
        chk("starve_after_instr", 32'(mem_instr), 32'h0);
        next_cycle(); mem_ready = 1'b1; mem_rdata = 32'h22; settle();
        chk("starve_after_dready", 32'(dmem_ready), 32'h1);

        // flush of an in-flight fetch
        next_cycle(); imem_valid = 1'b1; imem_addr = 32'h300; settle();
        next_cycle(); imem_flush = 1'b1; settle();
        chk("flush_fetch_addr", mem_addr, 32'h300);
        next_cycle();
        dmem_valid = 1'b1; dmem_addr = 32'hA000; dmem_wdata = 32'hDEADBEEF; dmem_wstrb = 4'hF;
        settle();
        next_cycle(); mem_ready = 1'b1; mem_rdata = 32'h77; settle();
        chk("flush_iready_low",  32'(imem_ready), 32'h0);
        chk("flush_irdata_hold", imem_rdata,      32'h11);
        next_cycle(); settle();
        chk("flush_st_valid", 32'(mem_valid), 32'h1);
        chk("flush_st_instr", 32'(mem_instr), 32'h0);
        chk("flush_st_addr",  mem_addr,       32'hA000);
        chk("flush_st_wdata", mem_wdata,      32'hDEADBEEF);
        chk("flush_st_wstrb", 32'(mem_wstrb), 32'hF);
        next_cycle(); mem_ready = 1'b1; mem_rdata = 32'h0; settle();
        chk("flush_st_dready", 32'(dmem_ready), 32'h1);

        // back-to-back loads
        next_cycle();
        dmem_valid = 1'b1; dmem_addr = 32'hB000; dmem_wdata = '0; dmem_wstrb = 4'h0;
        settle();
        next_cycle(); settle();
        chk("b2b_first_addr", mem_addr, 32'hB000);
        next_cycle();
        mem_ready = 1'b1; mem_rdata = 32'h1;
        dmem_valid = 1'b1; dmem_addr = 32'hB004;
        settle();
        chk("b2b_first_rdata", dmem_rdata, 32'h1);
        next_cycle(); settle();
        chk("b2b_second_valid", 32'(mem_valid), 32'h1);
        chk("b2b_second_addr",  mem_addr,       32'hB004);
        next_cycle(); mem_ready = 1'b1; mem_rdata = 32'h2; settle();
        chk("b2b_second_rdata", dmem_rdata, 32'h2);

        // asynchronous reset in the middle of a store
        next_cycle();
        dmem_valid = 1'b1; dmem_addr = 32'hC000; dmem_wdata = 32'h12345678; dmem_wstrb = 4'h3;
        settle();
        next_cycle(); settle();
        chk("areset_pre_valid", 32'(mem_valid), 32'h1);
        #2;
        rst = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("areset_mem_valid",  32'(mem_valid),  32'h0);
        chk("areset_mem_addr",   mem_addr,        32'h0);
        chk("areset_mem_wdata",  mem_wdata,       32'h0);
        chk("areset_mem_wstrb",  32'(mem_wstrb),  32'h0);
        chk("areset_dready",     32'(dmem_ready), 32'h0);
        chk("areset_drdata",     dmem_rdata,      32'h0);
        chk("areset_irdata",     imem_rdata,      32'h0);
        next_cycle(); rst = 1'b1; mem_ready = 1'b1; settle();
        chk("stale_dready", 32'(dmem_ready), 32'h0);
        chk("stale_iready", 32'(imem_ready), 32'h0);
        next_cycle(); settle();
        chk("stale_mem_valid", 32'(mem_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single external memory port between instruction fetch (imem) and the execute-stage load/store path (dmem).
- Each requester issues one-cycle request pulses. The arbiter buffers one pending request per side and grants in priority order.
- It drives the memory port with registered one-cycle valid pulses and routes mem_ready/mem_rdata back to the owning requester.
- It sits between the fetch/execute stages and the top-level memory interface.

Parameters:
- XLEN, 32, address/data width.
- STARVE_MAX, 4, maximum consecutive dmem grants while an imem request waits; after this, imem is forced next.

Ports:
- rst  input  1  asynchronous active-low reset
- clk  input  1  clock, rising edge
- imem_valid  input  1  fetch request pulse
- imem_addr  input  XLEN  fetch address
- imem_flush  input  1  discard pending/in-flight fetch (branch/exception redirect)
- imem_ready  output  1  fetch response valid (one cycle)
- imem_rdata  output  XLEN  fetch data
- dmem_valid  input  1  load/store request pulse
- dmem_addr  input  XLEN  data address
- dmem_wdata  input  XLEN  store data
- dmem_wstrb  input  XLEN/8  byte strobes; all zero = load
- dmem_ready  output  1  data response valid (one cycle)
- dmem_rdata  output  XLEN  load data
- mem_valid  output  1  memory request pulse (registered)
- mem_instr  output  1  1 = request is a fetch
- mem_addr  output  XLEN  memory address
- mem_wdata  output  XLEN  memory write data
- mem_wstrb  output  XLEN/8  memory byte strobes
- mem_ready  input  1  memory response valid
- mem_rdata  input  XLEN  memory read data

Behaviour:
- Reset (rst=0, async): state=IDLE; both pending buffers empty; starvation counter=0. All outputs 0: mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, imem_ready, imem_rdata, dmem_ready, dmem_rdata. Reset mid-transaction abandons it; a mem_ready arriving after reset release is ignored in IDLE.
- Pending buffers: a valid pulse captures addr/wdata/wstrb into that side's one-entry buffer. A new pulse on a side whose buffer is full or in flight is a protocol error; the buffer keeps the old request and the assertion fires.
- States: IDLE, IBUSY, DBUSY.
- IDLE, transitions at the clock edge:
  - Candidates are the buffered requests plus requests arriving this cycle.
  - dmem wins, except imem wins when starve_cnt==STARVE_MAX and imem is pending.
  - Winner goes to IBUSY/DBUSY. mem_valid=1 for exactly the next cycle, with mem_addr/wdata/wstrb/instr registered from the winner.
  - Latency: request pulse in cycle N in IDLE -> mem_valid in cycle N+1.
- IBUSY/DBUSY:
  - mem_valid=0 after the first cycle; address fields are held stable until mem_ready.
  - On mem_ready=1 in cycle M, imem_ready or dmem_ready=1 in the same cycle M (combinational), with rdata passed through. State returns to IDLE.
  - A new grant is possible at the edge ending cycle M, giving mem_valid in M+1 (back-to-back).
- Starvation counter:
  - Increments on each dmem grant while imem is pending, saturating at STARVE_MAX.
  - Clears on any imem grant or when imem is not pending.
- imem_flush:
  - Clears the imem pending buffer in the same cycle. A simultaneous imem_valid is kept, because the new fetch follows the flush.
  - If a fetch is in flight, sets drop flag; the matching mem_ready is consumed with imem_ready forced 0, and the flag is cleared.
  - Flush with nothing pending or in flight has no effect.
- Simultaneous imem_valid and dmem_valid in IDLE: dmem granted, imem buffered. The imem request is granted directly after the dmem mem_ready.
- mem_ready while IDLE is ignored; no response is emitted.
- dmem_rdata/imem_rdata hold their last value when ready=0.

Decomposition:
- Shared wires package:
  - arbiter_state_type enum (IDLE, IBUSY, DBUSY).
  - mem_req_type struct (valid, instr, addr, wdata, wstrb) used for both buffers and the mem port register.
  - init_mem_req constant.
- One sub-module, mem_req_buffer: a one-entry capture/hold/clear register instantiated twice (imem, dmem), with clear and flush inputs.

Test Plan:
- Single fetch: imem_valid pulse at cycle 2, addr 0x100. mem_valid=1/mem_instr=1 at cycle 3. Memory returns 0x00000013 with mem_ready at cycle 5 -> imem_ready=1, imem_rdata=0x13 at cycle 5.
- Collision: imem 0x200 and dmem load 0x8000 in the same cycle. Store/load at 0x8000 is issued first. The fetch at 0x200 is issued the cycle after the dmem mem_ready; both responses are routed correctly.
- Starvation: imem pending plus a dmem pulse after every response, with STARVE_MAX=4. Exactly 4 dmem grants occur, then the imem grant; the counter then reads 0.
- Flush in flight: fetch 0x300 is granted, imem_flush is asserted at the next cycle, then mem_ready arrives. imem_ready stays 0, and a following dmem store (wstrb=0xF, wdata=0xDEADBEEF) is granted next.
- Async reset: assert rst=0 mid-DBUSY, between clock edges. All outputs go to 0 immediately. After release, a stale mem_ready produces no dmem_ready.
- Back-to-back: two dmem loads, the second pulsed the cycle of the first response. mem_valid is re-asserted in the cycle immediately after the first mem_ready.
